pc_sequencer: RTL and testbench

- Multi-cycle program-counter controller for the single-cycle-to-multi-cycle ARM (LEGv8) datapath.
- Owns the PC register and one shared 64-bit adder, which it time-multiplexes between sequential increment (PC + 4) and branch-target computation (PC + offset<<2).
- Issues fetch addresses to instruction memory with a valid/ready handshake and waits for decode to report the branch decision before advancing.

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_sequencer_adder.sv | 15 +
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the multi-cycle program-counter controller.
package pc_sequencer_pkg;

  localparam int WORD = 64;

  // Byte distance between consecutive LEGv8 instructions.
  localparam logic [WORD-1:0] PC_STEP_DEF = 64'd4;

  // Controller states. The INCR/BRANCH split records the latched branch decision.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_INCR,
    ST_BRANCH
  } state_t;

endpackage

// File: rtl/pc_sequencer_adder.sv
// Common combinational adder, modulo 2^W with no carry-out.
module adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  // Plain wrap-around sum.
  always_comb begin
    sum = a + b;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: issues fetch addresses, waits for the decode
// decision, then updates the PC through one shared adder.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter logic [WORD-1:0] PC_STEP  = PC_STEP_DEF,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_ready,
  output logic             pc_valid,
  output logic [WORD-1:0]  pc_out,
  input  logic             instr_done,
  input  logic             branch_taken,
  input  logic [WORD-1:0]  branch_offset,
  input  logic             stall,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count
);

  state_t                 state;
  state_t                 state_next;
  logic signed [WORD-1:0] offset_q;
  logic [WORD-1:0]        add_a;
  logic [WORD-1:0]        add_b;
  logic [WORD-1:0]        add_sum;
  logic                   pc_load;
  logic                   offset_load;

  adder #(.W(WORD)) u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  // State register; reset aborts any in-flight update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, handshake outputs and adder operand mux. Stall freezes everything.
  always_comb begin
    state_next  = state;
    pc_valid    = 1'b0;
    busy        = 1'b1;
    add_a       = '0;
    add_b       = '0;
    pc_load     = 1'b0;
    offset_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!stall) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy     = 1'b0;
        pc_valid = !stall;
        if (!stall && fetch_ready) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!stall && instr_done) begin
          offset_load = 1'b1;
          state_next  = branch_taken ? ST_BRANCH : ST_INCR;
        end
      end
      ST_INCR: begin
        add_a = pc_out;
        add_b = PC_STEP;
        if (!stall) begin
          pc_load    = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_BRANCH: begin
        add_a = pc_out;
        add_b = offset_q << 2;
        if (!stall) begin
          pc_load    = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // PC, latched offset and retired counter; all cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out        <= RESET_PC;
      offset_q      <= '0;
      retired_count <= '0;
    end else begin
      if (offset_load) offset_q <= branch_offset;
      if (pc_load) begin
        pc_out        <= add_sum;
        retired_count <= retired_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// instruction streams checked against a transaction-level PC model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_ready;
  logic        instr_done;
  logic        branch_taken;
  logic [63:0] branch_offset;
  logic        stall;
  logic        pc_valid, busy;
  logic [63:0] pc_out;
  logic [31:0] retired_count;
  logic        w_pc_valid, w_busy;
  logic [63:0] w_pc_out;
  logic [31:0] w_retired_count;

  int tests = 0;
  int fails = 0;
  logic [63:0] model_pc;
  logic [31:0] model_cnt;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .pc_valid(pc_valid),
    .pc_out(pc_out), .instr_done(instr_done), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .stall(stall), .busy(busy),
    .retired_count(retired_count)
  );

  pc_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .pc_valid(w_pc_valid),
    .pc_out(w_pc_out), .instr_done(instr_done), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .stall(stall), .busy(w_busy),
    .retired_count(w_retired_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset asynchronously, confirm cleared outputs, then enter ISSUE.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_pc", pc_out, 64'h0);
    check("rst_valid", {63'd0, pc_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_cnt", {32'd0, retired_count}, 64'd0);
    tick();
    check("rst_hold_pc", pc_out, 64'h0);
    reset = 1'b0;
    tick();
    model_pc  = 64'h0;
    model_cnt = 32'd0;
    check("rst_issue_valid", {63'd0, pc_valid}, 64'd1);
  endtask

  // Fetch and decode as far as the decision edge; DUT is then in INCR/BRANCH.
  task automatic fetch_decide(input logic tkn, input logic [63:0] off, input int fr_dly,
                              input int st_issue, input int wt_dly, input int st_wait);
    for (int i = 0; i < fr_dly; i++) begin
      fetch_ready = 1'b0; stall = 1'b0; instr_done = 1'($urandom_range(0, 1));
      #1;
      check("issue_hold_valid", {63'd0, pc_valid}, 64'd1);
      check("issue_hold_pc", pc_out, model_pc);
      check("issue_busy", {63'd0, busy}, 64'd0);
      tick();
    end
    for (int i = 0; i < st_issue; i++) begin
      fetch_ready = 1'b1; stall = 1'b1; instr_done = 1'b0;
      #1;
      check("issue_stall_valid", {63'd0, pc_valid}, 64'd0);
      tick();
    end
    fetch_ready = 1'b1; stall = 1'b0; instr_done = 1'b0;
    #1;
    check("fetch_valid", {63'd0, pc_valid}, 64'd1);
    check("fetch_pc", pc_out, model_pc);
    check("fetch_cnt", {32'd0, retired_count}, {32'd0, model_cnt});
    tick();
    for (int i = 0; i < wt_dly; i++) begin
      fetch_ready = 1'($urandom_range(0, 1)); instr_done = 1'b0;
      #1;
      check("wait_valid", {63'd0, pc_valid}, 64'd0);
      check("wait_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    branch_taken = tkn; branch_offset = off;
    for (int i = 0; i < st_wait; i++) begin
      stall = 1'b1; instr_done = 1'b1; fetch_ready = 1'($urandom_range(0, 1));
      tick();
      check("wait_stall_pc", pc_out, model_pc);
    end
    stall = 1'b0; instr_done = 1'b1; fetch_ready = 1'b0;
    tick();
    instr_done = 1'b0;
    branch_taken = 1'($urandom_range(0, 1));
    branch_offset = {$urandom, $urandom};
  endtask

  // One complete instruction: fetch, decide, optionally stall the update, check result.
  task automatic do_instr(input logic tkn, input logic [63:0] off, input int fr_dly,
                          input int st_issue, input int wt_dly, input int st_wait,
                          input int st_upd);
    fetch_decide(tkn, off, fr_dly, st_issue, wt_dly, st_wait);
    for (int i = 0; i < st_upd; i++) begin
      stall = 1'b1;
      #1;
      check("upd_stall_pc", pc_out, model_pc);
      check("upd_stall_cnt", {32'd0, retired_count}, {32'd0, model_cnt});
      tick();
    end
    stall = 1'b0;
    tick();
    model_pc  = tkn ? model_pc + (off * 64'd4) : model_pc + 64'd4;
    model_cnt = model_cnt + 32'd1;
    #1;
    check("upd_pc", pc_out, model_pc);
    check("upd_cnt", {32'd0, retired_count}, {32'd0, model_cnt});
    check("upd_valid", {63'd0, pc_valid}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; fetch_ready = 1'b0; instr_done = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_offset = '0;
    tick();
    check("wrap_rst_pc", w_pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    do_reset();

    // Back-to-back sequential instructions, minimum spacing.
    do_instr(1'b0, 64'd0, 0, 0, 0, 0, 0);
    check("wrap_pc", w_pc_out, 64'h0);
    check("wrap_cnt", {32'd0, w_retired_count}, 64'd1);
    do_instr(1'b0, 64'd0, 0, 0, 0, 0, 0);
    do_instr(1'b0, 64'd0, 0, 0, 0, 0, 0);
    check("seq_pc12", pc_out, 64'd12);
    check("seq_cnt3", {32'd0, retired_count}, 64'd3);

    // Branches forward and backward.
    do_instr(1'b1, 64'd13, 0, 0, 0, 0, 0);
    check("br_to_40", pc_out, 64'h40);
    do_instr(1'b1, 64'h10, 0, 0, 0, 0, 0);
    check("br_to_80", pc_out, 64'h80);
    do_instr(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, 0, 0);
    check("br_back_40", pc_out, 64'h40);

    // Fetch backpressure and stall in WAIT with instr_done held.
    do_instr(1'b0, 64'd0, 5, 0, 0, 2, 0);
    check("hold_pc44", pc_out, 64'h44);

    // Reset during the BRANCH cycle discards the target.
    do_reset();
    do_instr(1'b1, 64'h40, 0, 0, 0, 0, 0);
    check("pre_rst_pc", pc_out, 64'h100);
    fetch_decide(1'b1, 64'd8, 0, 0, 0, 0);
    check("in_branch_pc", pc_out, 64'h100);
    do_reset();
    check("no_target", pc_out, 64'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      int fr, si, wd, sw, su;
      fr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      si = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      wd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      sw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      su = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_instr(1'($urandom_range(0, 1)), {$urandom, $urandom}, fr, si, wd, sw, su);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
